// File: rtl/datapath_pkg.sv
// Shared word type and ALU opcode constants for the datapath slice.
// Optional rotate support is selected with DATAPATH_ROTATE_EN.
package datapath_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  alu_op_t;

    localparam alu_op_t OP_ADD  = 5'b00000;
    localparam alu_op_t OP_SUB  = 5'b00001;
    localparam alu_op_t OP_AND  = 5'b00010;
    localparam alu_op_t OP_OR   = 5'b00011;
    localparam alu_op_t OP_SHR  = 5'b00100;
    localparam alu_op_t OP_SHL  = 5'b00101;
    localparam alu_op_t OP_SHRA = 5'b00110;
    localparam alu_op_t OP_ROR  = 5'b00111;
    localparam alu_op_t OP_ROL  = 5'b01000;
    localparam alu_op_t OP_NEG  = 5'b01001;
    localparam alu_op_t OP_NOT  = 5'b01010;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus; IncPC forces PC+1.
// ror/rol exist only when DATAPATH_ROTATE_EN is defined, otherwise they yield zero.
import datapath_pkg::*;

module datapath_alu (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [4:0]  op_i,
    input  logic        inc_pc_i,
    input  logic [31:0] pc_i,
    output logic [31:0] result_o
);

    logic [4:0] amt;
    assign amt = b_i[4:0];

`ifdef DATAPATH_ROTATE_EN
    // Rotates fall out of shifting a doubled copy of A.
    logic [63:0] dbl;
    logic [63:0] dbl_r;
    logic [63:0] dbl_l;
    assign dbl   = {a_i, a_i};
    assign dbl_r = dbl >> amt;
    assign dbl_l = dbl << amt;
`endif

    always_comb begin
        result_o = 32'h0;
        if (inc_pc_i) begin
            result_o = pc_i + 32'd1;
        end else begin
            case (op_i)
                OP_ADD:  result_o = a_i + b_i;
                OP_SUB:  result_o = a_i - b_i;
                OP_AND:  result_o = a_i & b_i;
                OP_OR:   result_o = a_i | b_i;
                OP_SHR:  result_o = a_i >> amt;
                OP_SHL:  result_o = a_i << amt;
                OP_SHRA: result_o = $unsigned($signed(a_i) >>> amt);
`ifdef DATAPATH_ROTATE_EN
                OP_ROR:  result_o = dbl_r[31:0];
                OP_ROL:  result_o = dbl_l[63:32];
`endif
                OP_NEG:  result_o = 32'h0 - b_i;
                OP_NOT:  result_o = ~b_i;
                default: result_o = 32'h0;
            endcase
        end
    end

endmodule

// File: rtl/datapath.sv
// Single-bus datapath: eight 32-bit registers, priority bus mux and ALU into ZLO.
// Build with DATAPATH_ROTATE_EN to enable the ALU rotate operations.
import datapath_pkg::*;

module datapath (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] MData_In,
    input  logic [4:0]  CONTROL,
    input  logic        IncPC,
    input  logic        Read,
    input  logic        PC_Out,
    input  logic        MDR_Out,
    input  logic        ZLO_Out,
    input  logic        R2_Out,
    input  logic        PC_In,
    input  logic        MDR_In,
    input  logic        MAR_In,
    input  logic        IR_In,
    input  logic        Y_In,
    input  logic        ZLO_In,
    input  logic        R2_In,
    input  logic        R5_In,
    output logic [31:0] BusMux_Out,
    output logic [31:0] MAR_Q
);

    word_t pc_q, mar_q, mdr_q, ir_q, y_q, zlo_q, r2_q, r5_q;
    word_t pc_d, mar_d, mdr_d, ir_d, y_d, zlo_d, r2_d, r5_d;
    word_t bus;
    word_t alu_result;

    // Fixed priority keeps the bus defined when several drivers are enabled.
    always_comb begin
        bus = 32'h0;
        if (PC_Out)       bus = pc_q;
        else if (MDR_Out) bus = mdr_q;
        else if (ZLO_Out) bus = zlo_q;
        else if (R2_Out)  bus = r2_q;
    end

    datapath_alu u_alu (
        .a_i      (y_q),
        .b_i      (bus),
        .op_i     (CONTROL),
        .inc_pc_i (IncPC),
        .pc_i     (pc_q),
        .result_o (alu_result)
    );

    always_comb begin
        pc_d  = PC_In  ? bus : pc_q;
        mar_d = MAR_In ? bus : mar_q;
        mdr_d = MDR_In ? (Read ? MData_In : bus) : mdr_q;
        ir_d  = IR_In  ? bus : ir_q;
        y_d   = Y_In   ? bus : y_q;
        zlo_d = ZLO_In ? alu_result : zlo_q;
        r2_d  = R2_In  ? bus : r2_q;
        r5_d  = R5_In  ? bus : r5_q;
    end

    // Clear wins over every load enable in the same cycle.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            pc_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            ir_q  <= '0;
            y_q   <= '0;
            zlo_q <= '0;
            r2_q  <= '0;
            r5_q  <= '0;
        end else begin
            pc_q  <= pc_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            ir_q  <= ir_d;
            y_q   <= y_d;
            zlo_q <= zlo_d;
            r2_q  <= r2_d;
            r5_q  <= r5_d;
        end
    end

    assign BusMux_Out = bus;
    assign MAR_Q      = mar_q;

endmodule

// File: tb/tb_datapath.sv
// Directed plus randomized bench for datapath against a register-level reference model.
// Define DATAPATH_ROTATE_EN consistently for RTL and bench.
module tb_datapath;

  logic        clk = 1'b0;
  logic        clear;
  logic [31:0] mdata;
  logic [4:0]  control;
  logic        inc_pc, read;
  logic        pc_out, mdr_out, zlo_out, r2_out;
  logic        pc_in, mdr_in, mar_in, ir_in, y_in, zlo_in, r2_in, r5_in;
  logic [31:0] bus_o, mar_o;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] m_pc, m_mar, m_mdr, m_ir, m_y, m_zlo, m_r2, m_r5;

  always #5 clk = ~clk;

  datapath dut (
    .Clock(clk), .Clear(clear), .MData_In(mdata), .CONTROL(control),
    .IncPC(inc_pc), .Read(read),
    .PC_Out(pc_out), .MDR_Out(mdr_out), .ZLO_Out(zlo_out), .R2_Out(r2_out),
    .PC_In(pc_in), .MDR_In(mdr_in), .MAR_In(mar_in), .IR_In(ir_in),
    .Y_In(y_in), .ZLO_In(zlo_in), .R2_In(r2_in), .R5_In(r5_in),
    .BusMux_Out(bus_o), .MAR_Q(mar_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op);
    int n;
    n = int'(b % 32);
    case (op)
      5'd0: return a + b;
      5'd1: return a - b;
      5'd2: return a & b;
      5'd3: return a | b;
      5'd4: return a >> n;
      5'd5: return a << n;
      5'd6: return (a[31] && n != 0) ? ((a >> n) | ~(32'hFFFF_FFFF >> n)) : (a >> n);
`ifdef DATAPATH_ROTATE_EN
      5'd7: return (n == 0) ? a : ((a >> n) | (a << (32 - n)));
      5'd8: return (n == 0) ? a : ((a << n) | (a >> (32 - n)));
`endif
      5'd9: return 32'd0 - b;
      5'd10: return ~b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_bus();
    if (pc_out) return m_pc;
    if (mdr_out) return m_mdr;
    if (zlo_out) return m_zlo;
    if (r2_out) return m_r2;
    return 32'd0;
  endfunction

  task automatic idle();
    clear = 0; mdata = 0; control = 0; inc_pc = 0; read = 0;
    pc_out = 0; mdr_out = 0; zlo_out = 0; r2_out = 0;
    pc_in = 0; mdr_in = 0; mar_in = 0; ir_in = 0; y_in = 0; zlo_in = 0; r2_in = 0; r5_in = 0;
  endtask

  // Called just after a rising edge: checks the bus mid-cycle, then the state after the edge.
  task automatic cyc(input string tag);
    logic [31:0] b, alu;
    #4;
    b = model_bus();
    chk({tag, " bus"}, bus_o, b);
    alu = inc_pc ? m_pc + 32'd1 : ref_alu(m_y, b, control);
    @(posedge clk);
    #1;
    if (clear) begin
      {m_pc, m_mar, m_mdr, m_ir, m_y, m_zlo, m_r2, m_r5} = '0;
    end else begin
      if (pc_in) m_pc = b;
      if (mar_in) m_mar = b;
      if (mdr_in) m_mdr = read ? mdata : b;
      if (ir_in) m_ir = b;
      if (y_in) m_y = b;
      if (zlo_in) m_zlo = alu;
      if (r2_in) m_r2 = b;
      if (r5_in) m_r5 = b;
    end
    chk({tag, " mar"}, mar_o, m_mar);
    chk({tag, " r5"}, dut.r5_q, m_r5);
    chk({tag, " ir"}, dut.ir_q, m_ir);
  endtask

  task automatic load_mdr(input string tag, input logic [31:0] v);
    idle(); mdata = v; read = 1; mdr_in = 1; cyc(tag);
  endtask

  task automatic peek_zlo(input string tag, input logic [31:0] v);
    idle(); zlo_out = 1; #1; chk(tag, bus_o, v);
  endtask

  initial begin
    idle();
    {m_pc, m_mar, m_mdr, m_ir, m_y, m_zlo, m_r2, m_r5} = '0;
    clear = 1;
    @(posedge clk); #1;
    cyc("reset");
    idle(); #1;
    chk("reset bus idle", bus_o, 32'd0);
    chk("reset mar", mar_o, 32'd0);
    idle(); pc_out = 1; cyc("reset pc");
    idle(); zlo_out = 1; cyc("reset zlo");

    load_mdr("ld16", 32'd16);
    idle(); mdr_out = 1; r2_in = 1; cyc("r2<-mdr");
    idle(); r2_out = 1; #1; chk("r2 is 16", bus_o, 32'd16);
    load_mdr("ld64", 32'd64);
    idle(); mdr_out = 1; r5_in = 1; cyc("r5<-mdr");
    chk("r5 is 64", dut.r5_q, 32'd64);

    idle(); pc_out = 1; mar_in = 1; inc_pc = 1; zlo_in = 1; cyc("fetch1");
    chk("fetch mar 0", mar_o, 32'd0);
    peek_zlo("fetch zlo 1", 32'd1);
    idle(); zlo_out = 1; pc_in = 1; cyc("fetch2");
    idle(); pc_out = 1; #1; chk("pc is 1", bus_o, 32'd1);

    idle(); mdr_out = 1; y_in = 1; cyc("y<-64");
    load_mdr("ld2", 32'd2);
    idle(); mdr_out = 1; control = 5'b00100; zlo_in = 1; cyc("shr");
    peek_zlo("shr zlo 16", 32'd16);
    idle(); zlo_out = 1; r5_in = 1; cyc("r5<-zlo");
    chk("r5 is 16", dut.r5_q, 32'd16);

    load_mdr("ldff", 32'hFFFF_FFFF);
    idle(); mdr_out = 1; y_in = 1; cyc("y<-ff");
    load_mdr("ld1", 32'd1);
    idle(); mdr_out = 1; control = 5'b00000; zlo_in = 1; cyc("add wrap");
    peek_zlo("add wrap zlo", 32'd0);
    idle(); y_in = 1; cyc("y<-0");
    idle(); mdr_out = 1; control = 5'b00001; zlo_in = 1; cyc("sub wrap");
    peek_zlo("sub wrap zlo", 32'hFFFF_FFFF);

    load_mdr("ld8001", 32'h8000_0001);
    idle(); mdr_out = 1; y_in = 1; cyc("y<-8001");
    load_mdr("ld1b", 32'd1);
    idle(); mdr_out = 1; control = 5'b00111; zlo_in = 1; cyc("ror");
`ifdef DATAPATH_ROTATE_EN
    peek_zlo("ror zlo", 32'hC000_0000);
`else
    peek_zlo("ror zlo", 32'h0);
`endif

    // ZLO driven and loaded together: old value on bus, new value stored.
    idle(); zlo_out = 1; zlo_in = 1; control = 5'b01010; cyc("zlo self");

    load_mdr("ld16b", 32'd16);
    idle(); mdr_out = 1; r2_in = 1; cyc("r2<-16");
    idle(); clear = 1; r2_in = 1; mdr_out = 1; mdata = 32'h55; cyc("clear mid");
    idle(); #1; chk("clear bus", bus_o, 32'd0);
    idle(); r2_out = 1; cyc("clear r2");
    idle(); mdr_out = 1; cyc("clear mdr");
    idle(); pc_out = 1; cyc("clear pc");

    for (int i = 0; i < 400; i++) begin
      idle();
      clear   = ($urandom_range(0, 39) == 0);
      mdata   = $urandom;
      control = 5'($urandom_range(0, 15));
      inc_pc  = ($urandom_range(0, 7) == 0);
      read    = 1'($urandom_range(0, 1));
      {pc_out, mdr_out, zlo_out, r2_out} = 4'($urandom_range(0, 15));
      {pc_in, mdr_in, mar_in, ir_in} = 4'($urandom_range(0, 15));
      {y_in, zlo_in, r2_in, r5_in} = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        mdata = 32'($urandom_range(0, 40));
      end
      cyc("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
